// File: rtl/demux_pkg.sv
// Shared types, lane constants and select-to-one-hot helper for the demux_1to4 slice.
// Revision: 1.0
`default_nettype none

package demux_pkg;

  typedef logic [1:0] lane_sel_t;

  localparam lane_sel_t LANE0     = 2'd0;
  localparam lane_sel_t LANE1     = 2'd1;
  localparam lane_sel_t LANE2     = 2'd2;
  localparam lane_sel_t LANE3     = 2'd3;
  localparam int        NUM_LANES = 4;

  function automatic logic [NUM_LANES-1:0] onehot4(input lane_sel_t s);
    onehot4 = 4'b0001 << s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux_1to4_if.sv
// Producer-to-demux bus: select/data/qualifier in, four lanes plus lane-valid flags out.
// Revision: 1.0
`default_nettype none

interface demux_1to4_if #(
  parameter int WIDTH = 1
) ();
  import demux_pkg::*;

  lane_sel_t              sel;
  logic [WIDTH-1:0]       i;
  logic                   in_valid;
  logic [WIDTH-1:0]       y0;
  logic [WIDTH-1:0]       y1;
  logic [WIDTH-1:0]       y2;
  logic [WIDTH-1:0]       y3;
  logic [NUM_LANES-1:0]   y_valid;

  modport master (
    output sel, i, in_valid,
    input  y0, y1, y2, y3, y_valid
  );

  modport slave (
    input  sel, i, in_valid,
    output y0, y1, y2, y3, y_valid
  );

endinterface

`default_nettype wire

// File: rtl/demux_1to4_sel_decode.sv
// demux_sel_decode: qualified select to one-hot lane enable, purely combinational.
// Revision: 1.0
`default_nettype none

module demux_sel_decode
  import demux_pkg::*;
(
  input  lane_sel_t             sel,
  input  logic                  in_valid,
  output logic [NUM_LANES-1:0]  en
);

  assign en = in_valid ? onehot4(sel) : '0;

endmodule

`default_nettype wire

// File: rtl/demux_1to4.sv
// demux_1to4: 1-to-4 demultiplexer, registered (REG_OUT=1) or combinational (REG_OUT=0).
// Revision: 1.0
`default_nettype none

module demux_1to4
  import demux_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  demux_1to4_if.slave     bus
);

  logic [NUM_LANES-1:0] w_en;
  logic [WIDTH-1:0]     w_lane [NUM_LANES];

  demux_sel_decode u_sel_decode (
    .sel      (bus.sel),
    .in_valid (bus.in_valid),
    .en       (w_en)
  );

  // Unselected lanes are forced to zero rather than holding stale data.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign w_lane[k] = bus.i & {WIDTH{w_en[k]}};
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0]     r_lane [NUM_LANES];
    logic [NUM_LANES-1:0] r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < NUM_LANES; k++) r_lane[k] <= '0;
        r_valid <= '0;
      end else begin
        for (int k = 0; k < NUM_LANES; k++) r_lane[k] <= w_lane[k];
        r_valid <= w_en;
      end
    end

    assign bus.y0      = r_lane[0];
    assign bus.y1      = r_lane[1];
    assign bus.y2      = r_lane[2];
    assign bus.y3      = r_lane[3];
    assign bus.y_valid = r_valid;
  end else begin : g_comb
    logic w_unused;
    assign w_unused    = clk ^ rst_n;

    assign bus.y0      = w_lane[0];
    assign bus.y1      = w_lane[1];
    assign bus.y2      = w_lane[2];
    assign bus.y3      = w_lane[3];
    assign bus.y_valid = w_en;
  end

endmodule

`default_nettype wire

// File: tb/tb_demux_1to4.sv
// Directed self-checking bench for demux_1to4: WIDTH=1 and WIDTH=8 registered, WIDTH=8 combinational.
// Revision: 1.0
`default_nettype none

module tb_demux_1to4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  demux_1to4_if #(.WIDTH(1)) bus1 ();
  demux_1to4_if #(.WIDTH(8)) bus8 ();
  demux_1to4_if #(.WIDTH(8)) busc ();

  demux_1to4 #(.WIDTH(1), .REG_OUT(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  demux_1to4 #(.WIDTH(8), .REG_OUT(1'b1)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  demux_1to4 #(.WIDTH(8), .REG_OUT(1'b0)) u_dutc (.clk(clk), .rst_n(rst_n), .bus(busc));

  task automatic test_reset();
    bus1.sel = 2'b10; bus1.i = 1'b1; bus1.in_valid = 1'b1;
    bus8.sel = 2'b01; bus8.i = 8'hFF; bus8.in_valid = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    n_checks++;
    if ({bus1.y3, bus1.y2, bus1.y1, bus1.y0} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_async lanes1: got %b expected 0000", {bus1.y3, bus1.y2, bus1.y1, bus1.y0});
    end
    n_checks++;
    if (bus1.y_valid !== 4'b0000) begin
      n_fail++; $display("FAIL reset_async valid1: got %b expected 0000", bus1.y_valid);
    end
    n_checks++;
    if ({bus8.y3, bus8.y2, bus8.y1, bus8.y0} !== 32'h0 || bus8.y_valid !== 4'b0000) begin
      n_fail++; $display("FAIL reset_async w8: got %h/%b expected 00000000/0000",
                         {bus8.y3, bus8.y2, bus8.y1, bus8.y0}, bus8.y_valid);
    end
    // Held in reset across a clock edge.
    @(posedge clk); #1;
    n_checks++;
    if ({bus1.y3, bus1.y2, bus1.y1, bus1.y0} !== 4'b0000 || bus1.y_valid !== 4'b0000) begin
      n_fail++; $display("FAIL reset_held: got %b/%b expected 0000/0000",
                         {bus1.y3, bus1.y2, bus1.y1, bus1.y0}, bus1.y_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({bus1.y3, bus1.y2, bus1.y1, bus1.y0} !== 4'b0100) begin
      n_fail++; $display("FAIL reset_release lanes1: got %b expected 0100", {bus1.y3, bus1.y2, bus1.y1, bus1.y0});
    end
    n_checks++;
    if (bus1.y_valid !== 4'b0100) begin
      n_fail++; $display("FAIL reset_release valid1: got %b expected 0100", bus1.y_valid);
    end
  endtask

  task automatic test_sweep();
    logic [1:0] t_sel   [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
    logic       t_i     [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] t_lanes [8] = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000};
    logic [3:0] t_valid [8] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      bus1.sel = t_sel[n]; bus1.i = t_i[n]; bus1.in_valid = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({bus1.y3, bus1.y2, bus1.y1, bus1.y0} !== t_lanes[n]) begin
        n_fail++; $display("FAIL sweep[%0d] lanes: got %b expected %b", n,
                           {bus1.y3, bus1.y2, bus1.y1, bus1.y0}, t_lanes[n]);
      end
      n_checks++;
      if (bus1.y_valid !== t_valid[n]) begin
        n_fail++; $display("FAIL sweep[%0d] valid: got %b expected %b", n, bus1.y_valid, t_valid[n]);
      end
    end
  endtask

  task automatic test_width8();
    @(negedge clk);
    bus8.sel = 2'b11; bus8.i = 8'hA5; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({bus8.y3, bus8.y2, bus8.y1, bus8.y0} !== 32'hA500_0000) begin
      n_fail++; $display("FAIL w8_sel3 lanes: got %h expected a5000000", {bus8.y3, bus8.y2, bus8.y1, bus8.y0});
    end
    n_checks++;
    if (bus8.y_valid !== 4'b1000) begin
      n_fail++; $display("FAIL w8_sel3 valid: got %b expected 1000", bus8.y_valid);
    end
    @(negedge clk);
    bus8.sel = 2'b00; bus8.i = 8'h3C;
    @(posedge clk); #1;
    n_checks++;
    if ({bus8.y3, bus8.y2, bus8.y1, bus8.y0} !== 32'h0000_003C) begin
      n_fail++; $display("FAIL w8_sel0 lanes: got %h expected 0000003c", {bus8.y3, bus8.y2, bus8.y1, bus8.y0});
    end
    n_checks++;
    if (bus8.y_valid !== 4'b0001) begin
      n_fail++; $display("FAIL w8_sel0 valid: got %b expected 0001", bus8.y_valid);
    end
  endtask

  task automatic test_in_valid();
    @(negedge clk);
    bus1.sel = 2'b10; bus1.i = 1'b1; bus1.in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({bus1.y3, bus1.y2, bus1.y1, bus1.y0} !== 4'b0000) begin
      n_fail++; $display("FAIL invalid lanes: got %b expected 0000", {bus1.y3, bus1.y2, bus1.y1, bus1.y0});
    end
    n_checks++;
    if (bus1.y_valid !== 4'b0000) begin
      n_fail++; $display("FAIL invalid valid: got %b expected 0000", bus1.y_valid);
    end
    @(negedge clk);
    bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({bus1.y3, bus1.y2, bus1.y1, bus1.y0} !== 4'b0100) begin
      n_fail++; $display("FAIL revalid lanes: got %b expected 0100", {bus1.y3, bus1.y2, bus1.y1, bus1.y0});
    end
    n_checks++;
    if (bus1.y_valid !== 4'b0100) begin
      n_fail++; $display("FAIL revalid valid: got %b expected 0100", bus1.y_valid);
    end
  endtask

  task automatic test_midstream_reset();
    logic [1:0] t_sel   [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [3:0] t_exp   [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      bus1.sel = t_sel[n]; bus1.i = 1'b1; bus1.in_valid = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({bus1.y3, bus1.y2, bus1.y1, bus1.y0} !== t_exp[n] || bus1.y_valid !== t_exp[n]) begin
        n_fail++; $display("FAIL stream[%0d]: got %b/%b expected %b/%b", n,
                           {bus1.y3, bus1.y2, bus1.y1, bus1.y0}, bus1.y_valid, t_exp[n], t_exp[n]);
      end
    end
    #1 rst_n = 1'b0; #1;
    n_checks++;
    if ({bus1.y3, bus1.y2, bus1.y1, bus1.y0} !== 4'b0000 || bus1.y_valid !== 4'b0000) begin
      n_fail++; $display("FAIL midreset_clear: got %b/%b expected 0000/0000",
                         {bus1.y3, bus1.y2, bus1.y1, bus1.y0}, bus1.y_valid);
    end
    @(negedge clk);
    rst_n = 1'b1; bus1.sel = 2'b01;
    @(posedge clk); #1;
    n_checks++;
    if ({bus1.y3, bus1.y2, bus1.y1, bus1.y0} !== 4'b0010 || bus1.y_valid !== 4'b0010) begin
      n_fail++; $display("FAIL midreset_resume: got %b/%b expected 0010/0010",
                         {bus1.y3, bus1.y2, bus1.y1, bus1.y0}, bus1.y_valid);
    end
  endtask

  task automatic test_comb();
    logic [1:0]  t_sel   [5] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b00};
    logic [7:0]  t_i     [5] = '{8'h5A, 8'hFF, 8'h00, 8'h81, 8'h81};
    logic        t_v     [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] t_lanes [5] = '{32'h005A_0000, 32'h0000_FF00, 32'h0000_0000, 32'h0000_0000, 32'h0000_0081};
    logic [3:0]  t_valid [5] = '{4'b0100, 4'b0010, 4'b1000, 4'b0000, 4'b0001};
    // Reset is held low throughout; the combinational variant must ignore it.
    rst_n = 1'b0;
    for (int n = 0; n < 5; n++) begin
      busc.sel = t_sel[n]; busc.i = t_i[n]; busc.in_valid = t_v[n];
      #3;
      n_checks++;
      if ({busc.y3, busc.y2, busc.y1, busc.y0} !== t_lanes[n]) begin
        n_fail++; $display("FAIL comb[%0d] lanes: got %h expected %h", n,
                           {busc.y3, busc.y2, busc.y1, busc.y0}, t_lanes[n]);
      end
      n_checks++;
      if (busc.y_valid !== t_valid[n]) begin
        n_fail++; $display("FAIL comb[%0d] valid: got %b expected %b", n, busc.y_valid, t_valid[n]);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    bus1.sel = 2'b00; bus1.i = '0; bus1.in_valid = 1'b0;
    bus8.sel = 2'b00; bus8.i = '0; bus8.in_valid = 1'b0;
    busc.sel = 2'b00; busc.i = '0; busc.in_valid = 1'b0;
    test_reset();
    test_sweep();
    test_width8();
    test_in_valid();
    test_midstream_reset();
    test_comb();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/demux_1to4.md
Name: demux_1to4

Overview:
Registered 1-to-4 demultiplexer. A 2-bit select steers the data input onto one of four output lanes; the three unselected lanes read zero. It sits between a single producer and four consumer lanes. Outputs are registered, so downstream timing is isolated from the select/data decode.

Parameters:
WIDTH, 1, data width in bits of the input and of each output lane (must be ≥1).
REG_OUT, 1, 1 = outputs registered (1-cycle latency); 0 = purely combinational path (clk/rst_n unused).

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
sel  input  2  lane select: 00→y0, 01→y1, 10→y2, 11→y3
i  input  WIDTH  data input
in_valid  input  1  qualifies sel/i for the current cycle
y0  output  WIDTH  lane 0 data
y1  output  WIDTH  lane 1 data
y2  output  WIDTH  lane 2 data
y3  output  WIDTH  lane 3 data
y_valid  output  4  one-hot lane-valid flags; bit k pairs with yk

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: while rst_n=0, y0..y3 = 0 and y_valid = 4'b0000, immediately and regardless of clk. Reset asserted mid-operation clears all outputs at once. First capture occurs on the first rising clk edge after rst_n deasserts.
- Decode, REG_OUT=1, at each rising clk edge:
  - If in_valid=1: y[sel] <= i; the other three lanes <= 0; y_valid <= one-hot(sel), i.e. 00→0001, 01→0010, 10→0100, 11→1000.
  - If in_valid=0: all lanes <= 0; y_valid <= 0000. Lanes are not held.
- Latency: exactly 1 cycle from sampled inputs to outputs. Inputs are resampled every cycle, with no internal state beyond the output registers. Back-to-back changes of sel and/or i are reflected cycle by cycle.
- With i=0 and in_valid=1: the selected lane shows 0, but its y_valid bit is still 1. This distinguishes valid zero data from "not selected".
- REG_OUT=0: the same decode function, applied combinationally. Outputs follow the inputs with zero latency. rst_n has no effect.
- All four sel codes are legal; there is no error or illegal state. Exactly one y_valid bit is set whenever in_valid=1.
- Width rule: data is passed bit-exact, with no extension or truncation. Unselected lanes are driven to all-zeros of WIDTH bits.

Decomposition:
- Shared package demux_pkg:
  - typedef lane_sel_t (2-bit);
  - constants LANE0..LANE3 = 2'd0..2'd3 and NUM_LANES = 4;
  - function onehot4(lane_sel_t) returning 4 bits.
- One sub-module: demux_sel_decode. It is a combinational sel + in_valid → 4-bit one-hot enable. The top uses it to gate i into each lane and into the y_valid register. The top holds the REG_OUT generate branch and the output registers.

Test Plan:
- Reset: assert rst_n=0 with i=1, sel=10, in_valid=1 → y0..y3=0 and y_valid=0000 immediately. Release rst_n; after the next edge → y2=1, y_valid=0100.
- Full sweep (WIDTH=1, in_valid=1): sel=00..11, each with i=0 then i=1, one value per cycle. One cycle later, only y[sel]=i and the other lanes are 0. Example: sel=01, i=1 → y0=0, y1=1, y2=0, y3=0, y_valid=0010. With i=0 the lanes are all 0 but y_valid is still one-hot.
- WIDTH=8: sel=11, i=8'hA5 → y3=A5, y0..y2=00, y_valid=1000. Next cycle, sel=00, i=8'h3C → y0=3C, y3=00.
- in_valid=0 with sel=10, i=1 → all lanes 0 and y_valid=0000 one cycle later. Re-asserting in_valid restores routing on the next cycle.
- Mid-stream reset: stream alternating sel every cycle, then pulse rst_n low between edges → outputs clear asynchronously within the same cycle and resume correctly after release.
- REG_OUT=0: change sel/i with no clock edges → outputs update combinationally and match the same truth table.
